ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Pipeline register between EX and MEM; the receiving end of the EX result and HI/LO write-request interface.
- Captures the EX write-back triple (wd, wreg, wdata) and the HI/LO write request (hi, lo, whilo) each cycle.
- Honours the stall vector: passes, bubbles or holds the stage.
- Stages the 64-bit partial accumulator and 2-bit step counter back to EX for two-cycle multiply-accumulate (madd/msub).

Parameters:
- DATA_W, 32, width of data and HI/LO words
- REG_ADDR_W, 5, width of destination register address
- STALL_W, 6, width of the pipeline stall vector; bit 3 = EX, bit 4 = MEM

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high (`RstEnable)
- stall  in  STALL_W  stall vector from stall controller
- ex_wd  in  REG_ADDR_W  EX destination register address
- ex_wreg  in  1  EX register write enable
- ex_wdata  in  DATA_W  EX result
- ex_hi  in  DATA_W  HI value to write
- ex_lo  in  DATA_W  LO value to write
- ex_whilo  in  1  HI/LO write enable
- hilo_i  in  2*DATA_W  partial accumulator from EX
- cnt_i  in  2  multi-cycle step counter from EX
- mem_wd  out  REG_ADDR_W  registered destination address
- mem_wreg  out  1  registered write enable
- mem_wdata  out  DATA_W  registered result
- mem_hi  out  DATA_W  registered HI value
- mem_lo  out  DATA_W  registered LO value
- mem_whilo  out  1  registered HI/LO write enable
- hilo_o  out  2*DATA_W  accumulator fed back to EX
- cnt_o  out  2  counter fed back to EX

Behaviour:
- Reset: rst high asynchronously forces all outputs to 0 (mem_wreg/mem_whilo = `WriteDisable). Outputs remain 0 while rst is held. Reset mid multi-cycle op discards the accumulator; cnt_o = 0.
- All non-reset updates are one-cycle latency, on the rising clk edge.
- Mode select, evaluated each edge with priority top to bottom:
  1. HOLD: stall[4]=1. All outputs keep their values. This includes stall[3]=0 with stall[4]=1, which the controller never issues; it is defined as HOLD.
  2. BUBBLE: stall[3]=1, stall[4]=0. mem_wd=0, mem_wreg=0, mem_wdata=0, mem_hi=0, mem_lo=0, mem_whilo=0. hilo_o<=hilo_i, cnt_o<=cnt_i, so EX can advance its multi-cycle op while stalled.
  3. PASS: stall[3]=0, stall[4]=0. mem_* <= ex_*. hilo_o<=0, cnt_o<=0, so the accumulator is cleared once EX releases.
- No write side effect may reach MEM during BUBBLE: mem_wreg and mem_whilo must be 0 on every bubble cycle.
- HI/LO fields are latched verbatim, including the unused half on mtlo/mthi; no masking is applied here.
- cnt_i is captured as-is with no saturation or wrap logic. EX owns counter semantics; values 0..3 pass through.
- Back-to-back PASS cycles sustain one instruction per cycle with no idle slot.
- A BUBBLE then PASS sequence gives mem_* = 0 for the bubble cycle, then the new ex_* values.

Optional Feature:
- Macro EX_MEM_MADD_EN.
- Defined: hilo_i/cnt_i staging behaves as described above.
- Undefined: hilo_o and cnt_o are tied to constant 0, and their flops are not instantiated. hilo_i/cnt_i are ignored. The mem_* path is unchanged.

Test Plan:
- Reset: assert rst mid-cycle with mem_wdata=32'h1234_5678 -> all outputs read 0 immediately, before the next clk edge.
- PASS: stall=6'b000000, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEAD_BEEF, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 -> next edge mem_wd=3, mem_wreg=1, mem_wdata=32'hDEAD_BEEF, mem_hi=1, mem_lo=2, mem_whilo=1, hilo_o=0, cnt_o=0.
- BUBBLE: stall=6'b001111, ex_wreg=1, hilo_i=64'h0000_0001_FFFF_FFFE, cnt_i=2'b01 -> next edge mem_wreg=0, mem_whilo=0, mem_wdata=0, hilo_o=64'h0000_0001_FFFF_FFFE, cnt_o=1.
- HOLD: after a PASS with mem_wdata=32'hA5A5_A5A5, apply stall=6'b011111 for 3 cycles while ex_* toggles -> all outputs unchanged for 3 edges.
- madd sequence: cycle 1 stall=6'b001111, cnt_i=1, hilo_i=64'd100; cycle 2 stall=0, ex_whilo=1, ex_hi=0, ex_lo=32'd150 -> cycle 1 edge hilo_o=100, cnt_o=1; cycle 2 edge mem_lo=150, mem_whilo=1, hilo_o=0, cnt_o=0.
- Macro off: repeat the BUBBLE scenario without EX_MEM_MADD_EN -> hilo_o=0 and cnt_o=0 on every cycle; mem_* as before.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: write-back triple, HI/LO request, and madd/msub accumulator staging (EX_MEM_MADD_EN).
// Latency: one cycle. Backpressure: stall[4] holds everything; stall[3] alone injects a bubble toward MEM.
// Without EX_MEM_MADD_EN the accumulator/counter feedback is constant zero and hilo_i/cnt_i are ignored.
module ex_mem_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STALL_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    logic ex_stall;
    logic mem_stall;

    assign ex_stall  = stall[3];
    assign mem_stall = stall[4];

    // A stalled MEM holds regardless of EX; a bubble must never carry a write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_whilo <= 1'b0;
        end else if (mem_stall) begin
            mem_wd    <= mem_wd;
            mem_wreg  <= mem_wreg;
            mem_wdata <= mem_wdata;
            mem_hi    <= mem_hi;
            mem_lo    <= mem_lo;
            mem_whilo <= mem_whilo;
        end else if (ex_stall) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_whilo <= 1'b0;
        end else begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            mem_whilo <= ex_whilo;
        end
    end

`ifdef EX_MEM_MADD_EN
    // The accumulator only advances while EX is stalled; releasing EX clears it for the next op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hilo_o <= '0;
            cnt_o  <= 2'd0;
        end else if (mem_stall) begin
            hilo_o <= hilo_o;
            cnt_o  <= cnt_o;
        end else if (ex_stall) begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end else begin
            hilo_o <= '0;
            cnt_o  <= 2'd0;
        end
    end

    logic unused_stall;
    assign unused_stall = ^{stall[2:0], stall[STALL_W-1:5]};
`else
    assign hilo_o = '0;
    assign cnt_o  = 2'd0;

    logic unused_madd;
    assign unused_madd = ^{hilo_i, cnt_i, stall[2:0], stall[STALL_W-1:5]};
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed vector bench for ex_mem_reg; expectations for hilo_o/cnt_o follow EX_MEM_MADD_EN.
module tb_ex_mem_reg;

`ifdef EX_MEM_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_reg #(.DATA_W(32), .REG_ADDR_W(5), .STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo_i;
        logic [1:0]  cnt_i;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_whilo;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] hi, input logic [31:0] lo,
                           input logic whilo, input logic [63:0] hilo, input logic [1:0] cnt);
        chk({tag, ".mem_wd"},    64'(mem_wd),    64'(wd));
        chk({tag, ".mem_wreg"},  64'(mem_wreg),  64'(wreg));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(wdata));
        chk({tag, ".mem_hi"},    64'(mem_hi),    64'(hi));
        chk({tag, ".mem_lo"},    64'(mem_lo),    64'(lo));
        chk({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(whilo));
        chk({tag, ".hilo_o"},    hilo_o,         MADD ? hilo : 64'd0);
        chk({tag, ".cnt_o"},     64'(cnt_o),     MADD ? 64'(cnt) : 64'd0);
    endtask

    task automatic drive(input logic [5:0] s, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] hi, input logic [31:0] lo,
                         input logic whilo, input logic [63:0] hl, input logic [1:0] c);
        stall = s; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_hi = hi; ex_lo = lo; ex_whilo = whilo; hilo_i = hl; cnt_i = c;
    endtask

    initial begin
        // stall, wd, wreg, wdata, hi, lo, whilo, hilo_i, cnt_i | expected outputs after the edge
        vecs[0]  = '{6'b000000, 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b1, 64'h55, 2'd3,
                     5'd3, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b1, 64'd0, 2'd0};
        vecs[1]  = '{6'b001111, 5'd7, 1'b1, 32'h1111_1111, 32'h9, 32'h8, 1'b1, 64'h0000_0001_FFFF_FFFE, 2'd1,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'h0000_0001_FFFF_FFFE, 2'd1};
        vecs[2]  = '{6'b011111, 5'd9, 1'b1, 32'h2222_2222, 32'h3, 32'h4, 1'b1, 64'h1234, 2'd2,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'h0000_0001_FFFF_FFFE, 2'd1};
        vecs[3]  = '{6'b010000, 5'd10, 1'b1, 32'h3333_3333, 32'h5, 32'h6, 1'b1, 64'h4321, 2'd3,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'h0000_0001_FFFF_FFFE, 2'd1};
        vecs[4]  = '{6'b000000, 5'd31, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0, 1'b0, 64'hABCD, 2'd2,
                     5'd31, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0, 1'b0, 64'd0, 2'd0};
        vecs[5]  = '{6'b001111, 5'd4, 1'b1, 32'h4444_4444, 32'h7, 32'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3};
        vecs[6]  = '{6'b001111, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd100, 2'd1,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd100, 2'd1};
        vecs[7]  = '{6'b000000, 5'd0, 1'b0, 32'd0, 32'd0, 32'd150, 1'b1, 64'd0, 2'd0,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd150, 1'b1, 64'd0, 2'd0};
        vecs[8]  = '{6'b011111, 5'd1, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 64'h99, 2'd3,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd150, 1'b1, 64'd0, 2'd0};
        vecs[9]  = '{6'b011111, 5'd2, 1'b0, 32'h0, 32'h2, 32'h2, 1'b1, 64'h98, 2'd2,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd150, 1'b1, 64'd0, 2'd0};
        vecs[10] = '{6'b011111, 5'd3, 1'b1, 32'h5A5A_5A5A, 32'h3, 32'h3, 1'b0, 64'h97, 2'd1,
                     5'd0, 1'b0, 32'd0, 32'd0, 32'd150, 1'b1, 64'd0, 2'd0};

        rst = 1'b1;
        drive(6'b000000, 5'd21, 1'b1, 32'hCAFE_0000, 32'h11, 32'h22, 1'b1, 64'h77, 2'd2);
        #2;
        chk_all("reset_init", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd0, 2'd0);
        @(posedge clk); #1;
        chk_all("reset_held", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].hi,
                  vecs[i].lo, vecs[i].whilo, vecs[i].hilo_i, vecs[i].cnt_i);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_wd, vecs[i].e_wreg, vecs[i].e_wdata,
                    vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_whilo, vecs[i].e_hilo, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Asynchronous reset between edges must clear outputs immediately.
        drive(6'b000000, 5'd12, 1'b1, 32'h1234_5678, 32'hAA, 32'hBB, 1'b1, 64'd0, 2'd0);
        @(posedge clk); #1;
        chk("pre_arst.mem_wdata", 64'(mem_wdata), 64'h1234_5678);
        #2 rst = 1'b1;
        #1;
        chk_all("arst_midcycle", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd0, 2'd0);
        @(posedge clk); #1;
        chk_all("arst_held", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a multi-cycle op discards the accumulator.
        drive(6'b001111, 5'd5, 1'b1, 32'h5, 32'h5, 32'h5, 1'b1, 64'hDEAD_0000_0000_0077, 2'd2);
        @(posedge clk); #1;
        chk_all("madd_step", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'hDEAD_0000_0000_0077, 2'd2);
        #2 rst = 1'b1;
        #1;
        chk_all("madd_reset", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back PASS after a bubble: one instruction per cycle.
        drive(6'b000000, 5'd6, 1'b1, 32'h0000_0006, 32'h6, 32'h6, 1'b0, 64'd0, 2'd0);
        @(posedge clk); #1;
        chk_all("b2b_0", 5'd6, 1'b1, 32'h6, 32'h6, 32'h6, 1'b0, 64'd0, 2'd0);
        @(negedge clk);
        drive(6'b000000, 5'd8, 1'b0, 32'h0000_0008, 32'h8, 32'h8, 1'b1, 64'h1, 2'd1);
        @(posedge clk); #1;
        chk_all("b2b_1", 5'd8, 1'b0, 32'h8, 32'h8, 32'h8, 1'b1, 64'd0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
